// File: rtl/wave_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wave_pkg
// Brief    : Shared constants for the waveform shaper / PWM audio output.
// Revision : 1.0 - initial release
// ============================================================================
package wave_pkg;

    localparam int SAMPLE_W   = 8;
    localparam int PWM_PERIOD = 255;

    localparam logic [1:0] WAVE_SQUARE = 2'd0;
    localparam logic [1:0] WAVE_SAW    = 2'd1;
    localparam logic [1:0] WAVE_TRI    = 2'd2;
    localparam logic [1:0] WAVE_SINE   = 2'd3;

    typedef logic [SAMPLE_W-1:0] sample_t;

endpackage
`default_nettype wire

// File: rtl/sine_quarter_rom.sv
`default_nettype none
// ============================================================================
// Module   : sine_quarter_rom
// Brief    : 64 x 7 synchronous quarter-wave sine ROM, q = round(127*sin((i+0.5)*pi/128)).
// Revision : 1.0 - initial release
// ============================================================================
module sine_quarter_rom (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [5:0] addr,
    output logic [6:0] q
);

    logic [6:0] w_rom;
    logic [6:0] r_q;

    always_comb begin
        w_rom = 7'd0;
        case (addr)
            6'd0:  w_rom = 7'd2;    6'd1:  w_rom = 7'd5;
            6'd2:  w_rom = 7'd8;    6'd3:  w_rom = 7'd11;
            6'd4:  w_rom = 7'd14;   6'd5:  w_rom = 7'd17;
            6'd6:  w_rom = 7'd20;   6'd7:  w_rom = 7'd23;
            6'd8:  w_rom = 7'd26;   6'd9:  w_rom = 7'd29;
            6'd10: w_rom = 7'd32;   6'd11: w_rom = 7'd35;
            6'd12: w_rom = 7'd38;   6'd13: w_rom = 7'd41;
            6'd14: w_rom = 7'd44;   6'd15: w_rom = 7'd47;
            6'd16: w_rom = 7'd50;   6'd17: w_rom = 7'd53;
            6'd18: w_rom = 7'd56;   6'd19: w_rom = 7'd58;
            6'd20: w_rom = 7'd61;   6'd21: w_rom = 7'd64;
            6'd22: w_rom = 7'd67;   6'd23: w_rom = 7'd69;
            6'd24: w_rom = 7'd72;   6'd25: w_rom = 7'd74;
            6'd26: w_rom = 7'd77;   6'd27: w_rom = 7'd79;
            6'd28: w_rom = 7'd82;   6'd29: w_rom = 7'd84;
            6'd30: w_rom = 7'd86;   6'd31: w_rom = 7'd89;
            6'd32: w_rom = 7'd91;   6'd33: w_rom = 7'd93;
            6'd34: w_rom = 7'd95;   6'd35: w_rom = 7'd97;
            6'd36: w_rom = 7'd99;   6'd37: w_rom = 7'd101;
            6'd38: w_rom = 7'd103;  6'd39: w_rom = 7'd105;
            6'd40: w_rom = 7'd106;  6'd41: w_rom = 7'd108;
            6'd42: w_rom = 7'd110;  6'd43: w_rom = 7'd111;
            6'd44: w_rom = 7'd113;  6'd45: w_rom = 7'd114;
            6'd46: w_rom = 7'd115;  6'd47: w_rom = 7'd117;
            6'd48: w_rom = 7'd118;  6'd49: w_rom = 7'd119;
            6'd50: w_rom = 7'd120;  6'd51: w_rom = 7'd121;
            6'd52: w_rom = 7'd122;  6'd53: w_rom = 7'd123;
            6'd54: w_rom = 7'd124;  6'd55: w_rom = 7'd124;
            6'd56: w_rom = 7'd125;  6'd57: w_rom = 7'd125;
            6'd58: w_rom = 7'd126;  6'd59: w_rom = 7'd126;
            6'd60: w_rom = 7'd127;  6'd61: w_rom = 7'd127;
            6'd62: w_rom = 7'd127;  6'd63: w_rom = 7'd127;
            default: w_rom = 7'd0;
        endcase
    end

    // Holds with the rest of stage 1 while the block is muted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= 7'd0;
        end else if (en) begin
            r_q <= w_rom;
        end
    end

    assign q = r_q;

endmodule
`default_nettype wire

// File: rtl/wave_pwm_out.sv
`default_nettype none
// ============================================================================
// Module   : wave_pwm_out
// Brief    : Phase-to-waveform shaper with volume scaling and glitch-free PWM output.
// Revision : 1.0 - initial release
// ============================================================================
module wave_pwm_out
    import wave_pkg::SAMPLE_W;
    import wave_pkg::WAVE_SQUARE;
    import wave_pkg::WAVE_SAW;
    import wave_pkg::WAVE_TRI;
    import wave_pkg::WAVE_SINE;
#(
    parameter int PWM_PERIOD = wave_pkg::PWM_PERIOD
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic [7:0]          phase,
    input  logic [1:0]          wave_sel,
    input  logic [3:0]          volume,
    output logic [SAMPLE_W-1:0] sample,
    output logic                sample_valid,
    output logic                pwm
);

    localparam logic [7:0] c_CNT_LAST = 8'(PWM_PERIOD - 1);

    // Stage 1
    logic [7:0]  r_phase;
    logic [1:0]  r_sel;
    logic [3:0]  r_vol;
    logic [5:0]  w_rom_addr;
    logic [6:0]  w_rom_q;
    // Stage 2
    logic [7:0]  w_raw;
    logic [7:0]  r_raw;
    logic [3:0]  r_vol2;
    // Stage 3 and PWM
    logic [4:0]  w_vol_p1;
    logic [11:0] w_prod;
    logic [7:0]  r_sample;
    logic [7:0]  r_cnt;
    logic [7:0]  r_duty;
    logic        r_valid;
    logic        r_pwm;
    logic        w_wrap;

    // Second quadrant of each half reads the quarter table backwards.
    assign w_rom_addr = phase[6] ? ~phase[5:0] : phase[5:0];

    sine_quarter_rom u_rom (
        .clk  (clk),
        .rst  (rst),
        .en   (enable),
        .addr (w_rom_addr),
        .q    (w_rom_q)
    );

    always_comb begin
        w_raw = 8'd0;
        case (r_sel)
            WAVE_SQUARE: w_raw = {8{r_phase[7]}};
            WAVE_SAW:    w_raw = r_phase;
            WAVE_TRI:    w_raw = r_phase[7] ? ~{r_phase[6:0], 1'b0} : {r_phase[6:0], 1'b0};
            WAVE_SINE:   w_raw = r_phase[7] ? (8'd127 - {1'b0, w_rom_q})
                                            : (8'd128 + {1'b0, w_rom_q});
            default:     w_raw = 8'd0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_phase <= 8'd0;
            r_sel   <= 2'd0;
            r_vol   <= 4'd0;
            r_raw   <= 8'd0;
            r_vol2  <= 4'd0;
        end else if (enable) begin
            r_phase <= phase;
            r_sel   <= wave_sel;
            r_vol   <= volume;
            r_raw   <= w_raw;
            r_vol2  <= r_vol;
        end
    end

    // (volume+1) in 1..16 keeps the 12-bit product from overflowing.
    assign w_vol_p1 = {1'b0, r_vol2} + 5'd1;
    assign w_prod   = {4'd0, r_raw} * {7'd0, w_vol_p1};
    assign w_wrap   = (r_cnt == c_CNT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sample <= 8'd0;
            r_cnt    <= 8'd0;
            r_duty   <= 8'd0;
            r_valid  <= 1'b0;
            r_pwm    <= 1'b0;
        end else if (!enable) begin
            r_sample <= 8'd0;
            r_cnt    <= 8'd0;
            r_duty   <= 8'd0;
            r_valid  <= 1'b0;
            r_pwm    <= 1'b0;
        end else begin
            r_sample <= w_prod[11:4];
            r_cnt    <= w_wrap ? 8'd0 : r_cnt + 8'd1;
            r_valid  <= w_wrap;
            r_pwm    <= (r_cnt < r_duty);
            if (w_wrap) begin
                r_duty <= r_sample;
            end
        end
    end

    assign sample       = r_sample;
    assign sample_valid = r_valid;
    assign pwm          = r_pwm;

endmodule
`default_nettype wire

// File: tb/tb_wave_pwm_out.sv
`default_nettype none
// ============================================================================
// Module   : tb_wave_pwm_out
// Brief    : Directed self-checking bench for wave_pwm_out.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wave_pwm_out;

    logic       clk;
    logic       rst;
    logic       enable;
    logic [7:0] phase;
    logic [1:0] wave_sel;
    logic [3:0] volume;
    logic [7:0] sample;
    logic       sample_valid;
    logic       pwm;

    int errors = 0;
    int checks = 0;

    wave_pwm_out #(.PWM_PERIOD(255)) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .phase        (phase),
        .wave_sel     (wave_sel),
        .volume       (volume),
        .sample       (sample),
        .sample_valid (sample_valid),
        .pwm          (pwm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts rising edges until sample_valid is seen; gives up after 600.
    task automatic wait_valid(output bit ok, output int edges);
        ok    = 1'b0;
        edges = 0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            edges++;
            if (sample_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        bit ok;
        int edges;
        rst = 1'b1; enable = 1'b0; phase = 8'd0; wave_sel = 2'd1; volume = 4'd15;
        repeat (3) @(negedge clk);
        checks++; if (sample !== 8'd0) begin errors++; $display("FAIL reset_sample: got %0d want 0", sample); end
        checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", sample_valid); end
        checks++; if (pwm !== 1'b0) begin errors++; $display("FAIL reset_pwm: got %b want 0", pwm); end
        rst = 1'b0; enable = 1'b1;
        wait_valid(ok, edges);
        checks++; if (!ok || edges != 255) begin errors++; $display("FAIL reset_first_valid: got %0d edges (seen=%0d) want 255", edges, ok); end
    endtask

    task automatic test_saw();
        bit ok;
        int edges;
        int highs;
        @(negedge clk);
        wave_sel = 2'd1; volume = 4'd15; phase = 8'd200;
        repeat (3) @(negedge clk);
        checks++; if (sample !== 8'd200) begin errors++; $display("FAIL saw_sample: got %0d want 200", sample); end
        wait_valid(ok, edges);
        checks++; if (!ok) begin errors++; $display("FAIL saw_valid_timeout: got none want pulse"); end
        highs = 0;
        for (int i = 0; i < 255; i++) begin
            @(negedge clk);
            if (pwm === 1'b1) highs++;
        end
        checks++; if (highs != 200) begin errors++; $display("FAIL saw_pwm_duty: got %0d want 200", highs); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        bit seen;
        int edges;
        seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (pwm === 1'b1) begin seen = 1'b1; break; end
        end
        checks++; if (!seen) begin errors++; $display("FAIL rstmid_pwm_high: got low want high before reset"); end
        #2 rst = 1'b1;
        #1;
        checks++; if (sample !== 8'd0) begin errors++; $display("FAIL rstmid_sample: got %0d want 0", sample); end
        checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %b want 0", sample_valid); end
        checks++; if (pwm !== 1'b0) begin errors++; $display("FAIL rstmid_pwm: got %b want 0", pwm); end
        @(negedge clk);
        rst = 1'b0;
        wait_valid(ok, edges);
        checks++; if (!ok || edges != 255) begin errors++; $display("FAIL rstmid_first_valid: got %0d edges want 255", edges); end
    endtask

    task automatic test_triangle_back_to_back();
        logic [7:0] ph  [4] = '{8'd64, 8'd128, 8'd255, 8'd0};
        logic [7:0] exp [4] = '{8'd128, 8'd255, 8'd1, 8'd0};
        @(negedge clk);
        wave_sel = 2'd2; volume = 4'd15;
        for (int i = 0; i < 7; i++) begin
            if (i >= 3) begin
                checks++;
                if (sample !== exp[i-3]) begin
                    errors++;
                    $display("FAIL tri_phase_%0d: got %0d want %0d", ph[i-3], sample, exp[i-3]);
                end
            end
            if (i < 4) phase = ph[i];
            @(negedge clk);
        end
    endtask

    task automatic test_sine();
        logic [7:0] ph  [4] = '{8'd64, 8'd192, 8'd0, 8'd128};
        logic [7:0] exp [4] = '{8'd255, 8'd0, 8'd130, 8'd125};
        wave_sel = 2'd3; volume = 4'd15;
        for (int i = 0; i < 4; i++) begin
            phase = ph[i];
            repeat (3) @(negedge clk);
            checks++;
            if (sample !== exp[i]) begin
                errors++;
                $display("FAIL sine_phase_%0d: got %0d want %0d", ph[i], sample, exp[i]);
            end
        end
    endtask

    task automatic test_volume();
        wave_sel = 2'd0; phase = 8'h80; volume = 4'd7;
        repeat (3) @(negedge clk);
        checks++; if (sample !== 8'd127) begin errors++; $display("FAIL vol7_square: got %0d want 127", sample); end
        volume = 4'd0;
        repeat (3) @(negedge clk);
        checks++; if (sample !== 8'd15) begin errors++; $display("FAIL vol0_square: got %0d want 15", sample); end
    endtask

    task automatic test_duty_extremes();
        bit ok;
        int edges;
        int highs;
        int lows;
        wave_sel = 2'd0; phase = 8'h00; volume = 4'd15;
        repeat (3) @(negedge clk);
        checks++; if (sample !== 8'd0) begin errors++; $display("FAIL duty0_sample: got %0d want 0", sample); end
        wait_valid(ok, edges);
        highs = 0;
        for (int i = 0; i < 255; i++) begin
            @(negedge clk);
            if (pwm !== 1'b0) highs++;
        end
        checks++; if (!ok || highs != 0) begin errors++; $display("FAIL duty0_pwm: got %0d high cycles want 0", highs); end
        phase = 8'h80;
        repeat (3) @(negedge clk);
        checks++; if (sample !== 8'd255) begin errors++; $display("FAIL duty255_sample: got %0d want 255", sample); end
        wait_valid(ok, edges);
        lows = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (pwm !== 1'b1) lows++;
        end
        checks++; if (!ok || lows != 0) begin errors++; $display("FAIL duty255_pwm: got %0d low cycles want 0", lows); end
    endtask

    task automatic test_enable_drop();
        bit ok;
        int edges;
        int highs;
        wait_valid(ok, edges);
        checks++; if (!ok) begin errors++; $display("FAIL endrop_sync_timeout: got none want pulse"); end
        repeat (100) @(negedge clk);
        checks++; if (pwm !== 1'b1) begin errors++; $display("FAIL endrop_pwm_before: got %b want 1", pwm); end
        enable = 1'b0;
        @(negedge clk);
        checks++; if (pwm !== 1'b0) begin errors++; $display("FAIL endrop_pwm_after: got %b want 0", pwm); end
        checks++; if (sample !== 8'd0) begin errors++; $display("FAIL endrop_sample: got %0d want 0", sample); end
        repeat (5) @(negedge clk);
        enable = 1'b1;
        ok = 1'b0; edges = 0; highs = 0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            edges++;
            if (sample_valid === 1'b1) begin ok = 1'b1; break; end
            if (pwm !== 1'b0) highs++;
        end
        checks++; if (!ok || edges != 255) begin errors++; $display("FAIL reenable_first_valid: got %0d edges want 255", edges); end
        checks++; if (highs != 0) begin errors++; $display("FAIL reenable_pwm_low: got %0d high cycles want 0", highs); end
        @(negedge clk);
        checks++; if (pwm !== 1'b1) begin errors++; $display("FAIL reenable_pwm_resume: got %b want 1", pwm); end
    endtask

    initial begin
        test_reset();
        test_saw();
        test_reset_mid();
        test_triangle_back_to_back();
        test_sine();
        test_volume();
        test_duty_extremes();
        test_enable_drop();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
